// File: rtl/pio_arb_pkg.sv
// Shared definitions for the PIO write arbiter: FSM states and Avalon constants.
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int AV_DATA_W       = 32;
  localparam int PIO_DATA_OFFSET = 0;

endpackage

// File: rtl/pio_write_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first asserted
// request at or after rr_ptr, scanning upward and wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    int                idx;
    logic [IDX_W-1:0]  idx_l;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    idx_l     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_l = IDX_W'(idx);
      if (req[idx_l]) begin
        gnt_idx   = idx_l;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_write_arbiter.sv
// Round-robin Avalon-MM master sharing one output PIO between requesters.
// Each grant performs a write, a readback and a compare, then acks the
// requester with a one-cycle pulse and a mismatch flag.
module pio_write_arbiter
  import pio_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 5,
  parameter int ADDR_W   = 2,
  parameter int PIO_ADDR = PIO_DATA_OFFSET
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      err,
  output logic [DATA_W-1:0]         last_value,
  output logic                      busy,
  output logic [ADDR_W-1:0]         address,
  output logic                      chipselect,
  output logic                      write_n,
  output logic [AV_DATA_W-1:0]      writedata,
  input  logic [AV_DATA_W-1:0]      readdata
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  g_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdback_q;
  logic [DATA_W-1:0] last_value_q;
  logic              mismatch;
  logic              unused_rd_hi;

  // Upper readback bits are not part of the PIO register.
  assign unused_rd_hi = ^readdata[AV_DATA_W-1:DATA_W];

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign mismatch = (rdback_q != wdata_q);

  // Next-state logic: a granted transaction always takes four cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = WRITE;
      WRITE:   state_d = READ;
      READ:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer and last good value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      last_value_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DONE) begin
        rr_ptr_q <= (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
        if (!mismatch) last_value_q <= wdata_q;
      end
    end
  end

  // Datapath latches: grant index and write data at grant, readback in READ.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && gnt_valid) begin
      g_q     <= gnt_idx;
      wdata_q <= req_data[gnt_idx*DATA_W +: DATA_W];
    end
    if (state_q == READ) rdback_q <= readdata[DATA_W-1:0];
  end

  // Outputs decoded from registered state only, so req never reaches the bus.
  always_comb begin
    busy       = (state_q != IDLE);
    chipselect = (state_q == WRITE) || (state_q == READ);
    write_n    = (state_q != WRITE);
    address    = '0;
    writedata  = '0;
    ack        = '0;
    err        = 1'b0;
    last_value = last_value_q;
    if (chipselect) address = ADDR_W'(PIO_ADDR);
    if (state_q == WRITE) writedata = {{(AV_DATA_W-DATA_W){1'b0}}, wdata_q};
    if (state_q == DONE) begin
      ack = {{(N_REQ-1){1'b0}}, 1'b1} << g_q;
      err = mismatch;
    end
  end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Bench for pio_write_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level model.
module tb_pio_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] req_data;
  logic [3:0]  ack;
  logic        err;
  logic [4:0]  last_value;
  logic        busy;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  logic [4:0]  pio_reg = 5'd0;
  logic        force_rd;
  logic [26:0] junk;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pio_write_arbiter #(
    .N_REQ(4), .DATA_W(5), .ADDR_W(2), .PIO_ADDR(0)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .last_value(last_value), .busy(busy),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata)
  );

  // PIO slave model: stores writes, returns stored value (or zero when corrupted).
  always @(posedge clk) if (chipselect && !write_n) pio_reg <= writedata[4:0];
  assign readdata = {junk, force_rd ? 5'd0 : pio_reg};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [19:0] rdata;
    bit          bad;
    logic [3:0]  ack;
    logic [4:0]  wd;
    bit          err;
    logic [4:0]  last;
  } vec_t;

  typedef struct {
    int         kind;   // 0 idle, 1 write, 2 read, 3 done
    logic [4:0] data;
    logic [3:0] ack;
    bit         bad;
  } ev_t;

  vec_t vt[8];
  ev_t  sched[$];

  initial begin
    vt[0] = '{4'b0010, {5'h00, 5'h00, 5'h15, 5'h00}, 1'b0, 4'b0010, 5'h15, 1'b0, 5'h15};
    vt[1] = '{4'b0101, {5'h00, 5'h0A, 5'h00, 5'h03}, 1'b0, 4'b0100, 5'h0A, 1'b0, 5'h0A};
    vt[2] = '{4'b1001, {5'h1C, 5'h00, 5'h00, 5'h11}, 1'b0, 4'b1000, 5'h1C, 1'b0, 5'h1C};
    vt[3] = '{4'b0001, {5'h00, 5'h00, 5'h00, 5'h1F}, 1'b1, 4'b0001, 5'h1F, 1'b1, 5'h1C};
    vt[4] = '{4'b1111, {5'h08, 5'h04, 5'h02, 5'h01}, 1'b0, 4'b0010, 5'h02, 1'b0, 5'h02};
    vt[5] = '{4'b0011, {5'h00, 5'h00, 5'h09, 5'h07}, 1'b0, 4'b0001, 5'h07, 1'b0, 5'h07};
    vt[6] = '{4'b0000, 20'h0,                        1'b0, 4'b0000, 5'h00, 1'b0, 5'h07};
    vt[7] = '{4'b0100, {5'h00, 5'h00, 5'h00, 5'h00}, 1'b1, 4'b0100, 5'h00, 1'b0, 5'h00};

    reset = 1'b1; req = '0; req_data = '0; force_rd = 1'b0; junk = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 4'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_last", last_value, 5'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus", {chipselect, write_n, address}, 4'b0100);
    chk("rst_wd", writedata, 32'h0);
    reset = 1'b0;

    // Table-driven single transactions; each starts with the arbiter idle.
    for (int i = 0; i < 8; i++) begin
      bit active;
      active   = (vt[i].req != 4'b0);
      req      = vt[i].req;
      req_data = vt[i].rdata;
      force_rd = vt[i].bad;
      junk     = 27'($urandom);
      @(negedge clk);
      chk($sformatf("v%0d_wr_ctrl", i), {chipselect, write_n, busy, address}, active ? 5'b10100 : 5'b01000);
      chk($sformatf("v%0d_wr_data", i), writedata, active ? {27'b0, vt[i].wd} : 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_rd_ctrl", i), {chipselect, write_n, busy}, active ? 3'b111 : 3'b010);
      chk($sformatf("v%0d_rd_data", i), writedata, 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), ack, vt[i].ack);
      chk($sformatf("v%0d_err", i), err, vt[i].err);
      chk($sformatf("v%0d_done_busy", i), busy, active);
      @(negedge clk);
      chk($sformatf("v%0d_after", i), {busy, ack}, 5'b0);
      chk($sformatf("v%0d_last", i), last_value, vt[i].last);
    end
    force_rd = 1'b0;

    // All four requesting continuously from reset: acks 0,1,2,3,0 every 4 cycles.
    reset = 1'b1; req = 4'b1111; req_data = {5'h08, 5'h04, 5'h02, 5'h01};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      logic [3:0] ea;
      @(negedge clk);
      ea = (c % 4 == 3) ? (4'b0001 << ((c / 4) % 4)) : 4'b0000;
      chk($sformatf("rr_c%0d_ack", c), ack, ea);
    end
    req = 4'b0;
    @(negedge clk);
    chk("rr_last", last_value, 5'h01);
    chk("rr_idle", busy, 1'b0);

    // Reset pulsed during READ drops the transaction; held req is re-granted.
    req = 4'b0001; req_data = {15'h0, 5'h0E};
    @(negedge clk);
    chk("rstrd_wd", writedata, 32'h0E);
    @(negedge clk);
    chk("rstrd_in_read", {chipselect, write_n}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("rstrd_noack", ack, 4'b0);
    chk("rstrd_bus", {chipselect, write_n, busy}, 3'b010);
    chk("rstrd_last", last_value, 5'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstrd_regrant_wd", writedata, 32'h0E);
    repeat (2) @(negedge clk);
    chk("rstrd_regrant_ack", {ack, err}, 5'b00010);
    @(negedge clk);
    chk("rstrd_regrant_last", last_value, 5'h0E);

    // req[0] dropped during WRITE: the transaction still completes and acks.
    req = 4'b0001; req_data = {15'h0, 5'h13};
    @(negedge clk);
    chk("drop_wd", writedata, 32'h13);
    req = 4'b0;
    repeat (2) @(negedge clk);
    chk("drop_ack", ack, 4'b0001);
    @(negedge clk);
    chk("drop_after", {busy, ack}, 5'b0);
    chk("drop_last", last_value, 5'h13);

    // Randomized run against a transaction-level model.
    begin
      logic [3:0] pend;
      logic [4:0] pdata[4];
      int         m_ptr;
      logic [4:0] m_last;
      pend = '0; m_ptr = 0; m_last = '0;
      for (int i = 0; i < 4; i++) pdata[i] = '0;
      reset = 1'b1; req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        ev_t        e;
        logic       ecs, ewn, ebusy, eerr;
        logic [4:0] rb;
        if (sched.size() > 0) e = sched.pop_front();
        else e = '{kind: 0, data: 5'h0, ack: 4'h0, bad: 1'b0};
        ecs   = (e.kind == 1) || (e.kind == 2);
        ewn   = (e.kind != 1);
        ebusy = (e.kind != 0);
        rb    = e.bad ? 5'h0 : e.data;
        eerr  = (e.kind == 3) && (rb != e.data);
        chk("rnd_ctrl", {chipselect, write_n, busy, address}, {ecs, ewn, ebusy, 2'b00});
        chk("rnd_wd", writedata, (e.kind == 1) ? {27'b0, e.data} : 32'h0);
        chk("rnd_ack_err", {ack, err}, {(e.kind == 3) ? e.ack : 4'b0, eerr});
        chk("rnd_last", last_value, m_last);
        if (e.kind == 3) begin
          if (!eerr) m_last = e.data;
          pend = pend & ~e.ack;
        end
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && $urandom_range(0, 3) == 0) begin
            pend[i]  = 1'b1;
            pdata[i] = 5'($urandom);
          end
        end
        req      = pend;
        req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
        force_rd = (e.kind == 2) && e.bad;
        junk     = 27'($urandom);
        if (e.kind == 0 && pend != 4'b0) begin
          int  g;
          bit  found;
          bit  bad;
          g = 0; found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (!found && pend[idx]) begin g = idx; found = 1'b1; end
          end
          bad = ($urandom_range(0, 5) == 0);
          sched.push_back('{kind: 1, data: pdata[g], ack: 4'h0, bad: bad});
          sched.push_back('{kind: 2, data: pdata[g], ack: 4'h0, bad: bad});
          sched.push_back('{kind: 3, data: pdata[g], ack: 4'b0001 << g, bad: bad});
          m_ptr = (g + 1) % 4;
        end
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
